ecc_point_ctrl: RTL
===================

# ecc_point_ctrl

Sequencer directly upstream of the GF arithmetic unit (GFAU). It accepts an elliptic-curve point operation (P+Q or 2P over y² = x³ + ax + b mod p) and decomposes it into a fixed micro-op program of GF add/sub/mult/div. It issues each micro-op to the GFAU, stores intermediates, and returns the resulting point. Field operands are already reduced mod p by the requester.

## Interface
- WIDTH, 32, field element width; matches GFAU in_0/in_1/prime/result.
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous reset, active-high.
- i_start  in  1  one-cycle request; honoured only in IDLE.
- i_mode  in  1  0 = add (P+Q), 1 = double (2P).
- i_x1, i_y1, i_x2, i_y2  in  WIDTH  operand points; x2/y2 ignored in double mode.
- i_a  in  WIDTH  curve coefficient a.
- i_prime  in  WIDTH  field prime p.
- o_x3, o_y3  out  WIDTH  result point.
- o_done  out  1  one-cycle pulse: program finished (success or error).
- o_err  out  1  denominator zero; valid with o_done, held until next start.
- o_busy  out  1  high in every state except IDLE.
- gf_in_0, gf_in_1, gf_prime  out  WIDTH  GFAU operands (to in_0/in_1/prime).
- gf_op  out  2  GFAU operation_select: 00 add, 01 sub, 10 mult, 11 div (in_0 / in_1).
- gf_done_from_control  out  1  result-consumed acknowledge to GFAU.
- gf_result  in  WIDTH  GFAU result.
- gf_done_to_control  in  1  GFAU result valid.

## Operation
- On accepted start: latch all i_* operands into internal registers; clear o_err; step counter = 0. Later input changes have no effect.
- Scratch registers: t0…t5 and lam (WIDTH each). Each micro-op names two sources and one destination.
- Add program (9 ops): t0=y2−y1; t1=x2−x1; lam=t0/t1; t2=lam·lam; t3=t2−x1; x3=t3−x2; t4=x1−x3; t5=lam·t4; y3=t5−y1.
- Double program (12 ops): t0=x1·x1; t1=t0+t0; t1=t1+t0; t1=t1+a; t2=y1+y1; lam=t1/t2; t3=lam·lam; t3=t3−x1; x3=t3−x1; t4=x1−x3; t5=lam·t4; y3=t5−y1.
- Zero check: before issuing a div, if the divisor register == 0, do not issue. Go to DONE with o_err=1; o_x3/o_y3 = 0.
- States: IDLE → ISSUE (start) → WAIT → ACK → ISSUE (more ops) or DONE (last op) → IDLE. ISSUE → DONE directly on a zero divisor.
- ISSUE: drive gf_op/gf_in_0/gf_in_1/gf_prime for current op. These hold stable through WAIT and ACK.
- WAIT: stay until gf_done_to_control=1; on that edge write gf_result to the destination register.
- ACK: gf_done_from_control=1 for exactly this cycle; increment step.
- DONE: o_done=1 one cycle; o_x3/o_y3 hold until next accepted start.
- gf_done_to_control outside WAIT: ignored. i_start while busy: ignored, no queueing.
- No internal mod reduction: all arithmetic is delegated to the GFAU.

## Timing
- Reset (sync, any state, including mid-program): state=IDLE. o_x3, o_y3, o_done, o_err, o_busy, gf_in_0, gf_in_1, gf_prime, gf_op, gf_done_from_control all 0. Scratch registers cleared. Outstanding GFAU op abandoned; no ACK issued.
- Cycle n: i_start sampled in IDLE. Cycle n+1: ISSUE, o_busy=1.
- Per op: ISSUE 1 cycle, WAIT ≥1 cycle, ACK 1 cycle. A GFAU answering in the first WAIT cycle gives 3 cycles per op.
- Total with zero-latency GFAU: add 27 + 1 (DONE) cycles after start; double 36 + 1.
- o_done asserts the cycle after the final ACK. o_busy drops the cycle after DONE, and a new i_start is accepted in that cycle.
- Error exit: o_done in the cycle after the ISSUE that detected the zero divisor.

## Test plan
- Double, p=17, a=2, (x1,y1)=(5,1), GFAU model with 1-cycle latency -> o_x3=6, o_y3=3, o_err=0. Exactly 12 ACK pulses, gf_op sequence 10,00,00,00,00,11,10,01,01,01,10,01.
- Add, p=17, (5,1)+(6,3) -> o_x3=10, o_y3=6, o_err=0, 9 ACK pulses. Also verify lam register = 2.
- Add, p=17, (5,1)+(5,16) -> 2 sub ops issued, no div, o_done with o_err=1, o_x3=o_y3=0.
- Variable GFAU latency (0–7 random WAIT cycles) plus spurious gf_done_to_control outside WAIT -> results identical to test 1; ignored dones cause no register write.
- i_start pulsed during WAIT of test 2 -> ignored. Assert i_rst mid-program -> next cycle all outputs 0, IDLE. A following start reruns test 2 correctly.
- Back-to-back: i_start in the cycle o_busy drops -> accepted, second result correct.

Source files
------------

// File: rtl/ecc_point_ctrl.sv
// ecc_point_ctrl
// ---------------
// Sequencer that sits directly in front of a GF arithmetic unit (GFAU). It
// turns one elliptic-curve point operation (P+Q or 2P on y^2 = x^3 + ax + b
// mod p) into a fixed program of GF add/sub/mult/div micro-ops. Each micro-op
// goes through ISSUE -> WAIT -> ACK. Intermediates are kept in a small
// register file, and the result point is returned with a one-cycle done pulse.
// All modular arithmetic is done by the GFAU.
//
// Ports
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_start, i_mode         request pulse (IDLE only); 0 = P+Q, 1 = 2P
//   i_x1,i_y1,i_x2,i_y2     operand points (x2/y2 unused when doubling)
//   i_a, i_prime            curve coefficient a, field prime p
//   o_x3, o_y3              result point, held until the next accepted start
//   o_done, o_err, o_busy   done pulse, zero-divisor flag, not-IDLE flag
//   gf_in_0/1, gf_prime     GFAU operands
//   gf_op                   GFAU op: 00 add, 01 sub, 10 mult, 11 div
//   gf_done_from_control    result-consumed acknowledge (ACK cycle)
//   gf_result               GFAU result
//   gf_done_to_control      GFAU result valid (used only in WAIT)
module ecc_point_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_x1,
    input  logic [WIDTH-1:0] i_y1,
    input  logic [WIDTH-1:0] i_x2,
    input  logic [WIDTH-1:0] i_y2,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_prime,
    output logic [WIDTH-1:0] o_x3,
    output logic [WIDTH-1:0] o_y3,
    output logic             o_done,
    output logic             o_err,
    output logic             o_busy,
    output logic [WIDTH-1:0] gf_in_0,
    output logic [WIDTH-1:0] gf_in_1,
    output logic [WIDTH-1:0] gf_prime,
    output logic [1:0]       gf_op,
    output logic             gf_done_from_control,
    input  logic [WIDTH-1:0] gf_result,
    input  logic             gf_done_to_control
);

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_ACK, S_DONE
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11
    } gf_op_e;

    // Register-file slots: latched operands, scratch, and result.
    typedef enum logic [3:0] {
        R_X1, R_Y1, R_X2, R_Y2, R_A,
        R_T0, R_T1, R_T2, R_T3, R_T4, R_T5, R_LAM,
        R_X3, R_Y3
    } reg_e;

    typedef struct packed {
        gf_op_e op;
        reg_e   src0;
        reg_e   src1;
        reg_e   dst;
    } uop_t;

    // Micro-op program ROM: dst = src0 <op> src1.
    function automatic uop_t uop_lookup(input logic mode, input logic [3:0] step);
        uop_t u;
        u = '{op: OP_ADD, src0: R_X1, src1: R_X1, dst: R_T0};
        if (!mode) begin
            case (step)
                4'd0:    u = '{OP_SUB, R_Y2,  R_Y1,  R_T0};
                4'd1:    u = '{OP_SUB, R_X2,  R_X1,  R_T1};
                4'd2:    u = '{OP_DIV, R_T0,  R_T1,  R_LAM};
                4'd3:    u = '{OP_MUL, R_LAM, R_LAM, R_T2};
                4'd4:    u = '{OP_SUB, R_T2,  R_X1,  R_T3};
                4'd5:    u = '{OP_SUB, R_T3,  R_X2,  R_X3};
                4'd6:    u = '{OP_SUB, R_X1,  R_X3,  R_T4};
                4'd7:    u = '{OP_MUL, R_LAM, R_T4,  R_T5};
                4'd8:    u = '{OP_SUB, R_T5,  R_Y1,  R_Y3};
                default: u = '{OP_ADD, R_X1,  R_X1,  R_T0};
            endcase
        end else begin
            case (step)
                4'd0:    u = '{OP_MUL, R_X1,  R_X1,  R_T0};
                4'd1:    u = '{OP_ADD, R_T0,  R_T0,  R_T1};
                4'd2:    u = '{OP_ADD, R_T1,  R_T0,  R_T1};
                4'd3:    u = '{OP_ADD, R_T1,  R_A,   R_T1};
                4'd4:    u = '{OP_ADD, R_Y1,  R_Y1,  R_T2};
                4'd5:    u = '{OP_DIV, R_T1,  R_T2,  R_LAM};
                4'd6:    u = '{OP_MUL, R_LAM, R_LAM, R_T3};
                4'd7:    u = '{OP_SUB, R_T3,  R_X1,  R_T3};
                4'd8:    u = '{OP_SUB, R_T3,  R_X1,  R_X3};
                4'd9:    u = '{OP_SUB, R_X1,  R_X3,  R_T4};
                4'd10:   u = '{OP_MUL, R_LAM, R_T4,  R_T5};
                4'd11:   u = '{OP_SUB, R_T5,  R_Y1,  R_Y3};
                default: u = '{OP_ADD, R_X1,  R_X1,  R_T0};
            endcase
        end
        return u;
    endfunction

    state_e           state_q;
    logic [3:0]       step_q;
    logic             mode_q;
    logic [WIDTH-1:0] prime_q;
    reg_e             dst_q;
    logic             zero_div_q;
    logic [WIDTH-1:0] rf_q [16];

    gf_op_e           gf_op_q;
    logic [WIDTH-1:0] gf_in_0_q, gf_in_1_q, gf_prime_q;
    logic             ack_q, done_q, err_q, busy_q;
    logic [WIDTH-1:0] x3_q, y3_q;

    // Decode of the op about to be loaded into the GFAU operand registers.
    logic [WIDTH-1:0] view_d [16];
    logic             mode_d;
    logic [3:0]       step_d;
    uop_t             uop_d;
    logic [WIDTH-1:0] in0_d, in1_d, prime_d;
    logic             zero_div_d;
    logic             last_step_d;
    logic             load_d;

    // NOTE: every signal assigned in this always_comb gets a default at the
    // top, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            view_d[i] = rf_q[i];
        end
        mode_d  = mode_q;
        step_d  = step_q + 4'd1;
        prime_d = prime_q;
        // On the start edge the operands are not latched yet, so the first op
        // reads them straight from the inputs.
        if (state_q == S_IDLE) begin
            view_d[R_X1] = i_x1;
            view_d[R_Y1] = i_y1;
            view_d[R_X2] = i_x2;
            view_d[R_Y2] = i_y2;
            view_d[R_A]  = i_a;
            mode_d       = i_mode;
            step_d       = 4'd0;
            prime_d      = i_prime;
        end
        uop_d       = uop_lookup(mode_d, step_d);
        in0_d       = view_d[uop_d.src0];
        in1_d       = view_d[uop_d.src1];
        zero_div_d  = (uop_d.op == OP_DIV) && (in1_d == '0);
        last_step_d = mode_q ? (step_q == 4'd11) : (step_q == 4'd8);
        load_d      = ((state_q == S_IDLE) && i_start) ||
                      ((state_q == S_ACK) && !last_step_d);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            mode_q     <= 1'b0;
            prime_q    <= '0;
            dst_q      <= R_T0;
            zero_div_q <= 1'b0;
            gf_op_q    <= OP_ADD;
            gf_in_0_q  <= '0;
            gf_in_1_q  <= '0;
            gf_prime_q <= '0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            x3_q       <= '0;
            y3_q       <= '0;
            // NOTE: the register file is small and is cleared on reset so no
            // stale intermediate survives an abandoned program.
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            ack_q  <= 1'b0;
            done_q <= 1'b0;

            // Load the next op's operands as the FSM enters ISSUE. A zero
            // divisor is never presented: operands go to 0 and ISSUE exits.
            if (load_d) begin
                dst_q      <= uop_d.dst;
                zero_div_q <= zero_div_d;
                if (zero_div_d) begin
                    gf_op_q    <= OP_ADD;
                    gf_in_0_q  <= '0;
                    gf_in_1_q  <= '0;
                    gf_prime_q <= '0;
                end else begin
                    gf_op_q    <= uop_d.op;
                    gf_in_0_q  <= in0_d;
                    gf_in_1_q  <= in1_d;
                    gf_prime_q <= prime_d;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        rf_q[R_X1] <= i_x1;
                        rf_q[R_Y1] <= i_y1;
                        rf_q[R_X2] <= i_x2;
                        rf_q[R_Y2] <= i_y2;
                        rf_q[R_A]  <= i_a;
                        mode_q     <= i_mode;
                        prime_q    <= i_prime;
                        step_q     <= '0;
                        err_q      <= 1'b0;
                        x3_q       <= '0;
                        y3_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (zero_div_q) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        x3_q    <= '0;
                        y3_q    <= '0;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (gf_done_to_control) begin
                        rf_q[dst_q] <= gf_result;
                        ack_q       <= 1'b1;
                        state_q     <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (last_step_d) begin
                        x3_q    <= rf_q[R_X3];
                        y3_q    <= rf_q[R_Y3];
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        step_q  <= step_q + 4'd1;
                        state_q <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_x3                 = x3_q;
    assign o_y3                 = y3_q;
    assign o_done               = done_q;
    assign o_err                = err_q;
    assign o_busy               = busy_q;
    assign gf_in_0              = gf_in_0_q;
    assign gf_in_1              = gf_in_1_q;
    assign gf_prime             = gf_prime_q;
    assign gf_op                = gf_op_q;
    assign gf_done_from_control = ack_q;

endmodule
